// File: rtl/memory_interface_types.sv
// Shared memory_interface types: responder FSM states and bus-width defaults used
// by both the L1 cache (master) and memory_responder (slave).
package memory_interface_types;

   typedef enum logic {MEM_IDLE, MEM_BUSY} mem_resp_state_t;

   localparam int MEM_LINE_SIZE = 256;
   localparam int MEM_ADDR_SIZE = 32;

   // Byte-offset bits within one line of the given width.
   function automatic int line_off_bits(input int line_size);
      return $clog2(line_size / 8);
   endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with 16'hACE1 on reset,
// advancing one step per cycle that step_i is high.
module lfsr16 (
   input  logic        clk_i,
   input  logic        reset_ni,
   input  logic        step_i,
   output logic [15:0] value_o
);

   logic fb;
   assign fb = value_o[15] ^ value_o[13] ^ value_o[12] ^ value_o[10];

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni)   value_o <= 16'hACE1;
      else if (step_i) value_o <= {value_o[14:0], fb};
   end

endmodule

// File: rtl/memory_responder.sv
// Line-granular backing store on the slave side of memory_interface; one request in flight.
// Optional feature macro MEM_RANDOM_LATENCY_EN adds 0..3 LFSR-driven cycles per request.
import memory_interface_types::*;

module memory_responder #(
   parameter int DEPTH_LINES = 1024,
   parameter int LINE_SIZE   = MEM_LINE_SIZE,
   parameter int ADDR_SIZE   = MEM_ADDR_SIZE,
   parameter int LATENCY     = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 valid,
   input  logic                 write,
   input  logic [ADDR_SIZE-1:0] addr,
   input  logic [LINE_SIZE-1:0] wr_data,
   output logic [LINE_SIZE-1:0] rd_data,
   output logic                 ready
);

   localparam int OFF_BITS = line_off_bits(LINE_SIZE);
   localparam int IDX_BITS = $clog2(DEPTH_LINES);
   localparam int CNT_W    = $clog2(LATENCY + 4);

   if (LATENCY < 1) begin : g_bad_latency
      $error("memory_responder: LATENCY must be >= 1");
   end
   if ((1 << IDX_BITS) != DEPTH_LINES) begin : g_bad_depth
      $error("memory_responder: DEPTH_LINES must be a power of two");
   end

   typedef struct packed {
      logic                 write;
      logic [IDX_BITS-1:0]  idx;
      logic [LINE_SIZE-1:0] data;
   } req_t;

   mem_resp_state_t      state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d, busy_load;
   req_t                 req_q, req_d;
   logic                 ready_q, ready_d;
   logic                 accept, commit_wr, commit_rd;

   logic [LINE_SIZE-1:0] mem [DEPTH_LINES];

   // Upper address bits alias onto the array; offset bits select nothing.
   logic unused_addr;
   assign unused_addr = ^{addr[ADDR_SIZE-1:OFF_BITS+IDX_BITS], addr[OFF_BITS-1:0]};

`ifdef MEM_RANDOM_LATENCY_EN
   logic [15:0] lfsr_val;
   logic [13:0] unused_lfsr;

   lfsr16 u_lfsr (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .step_i  (accept),
      .value_o (lfsr_val)
   );

   assign unused_lfsr = lfsr_val[15:2];
   // Busy time LATENCY..LATENCY+3; counter holds busy time minus one.
   assign busy_load   = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_val[1:0]);
`else
   assign busy_load   = CNT_W'(LATENCY - 1);
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      ready_d   = ready_q;
      accept    = 1'b0;
      commit_wr = 1'b0;
      commit_rd = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            ready_d = 1'b1;
            if (valid && ready_q) begin
               accept     = 1'b1;
               req_d.write = write;
               req_d.idx   = addr[OFF_BITS +: IDX_BITS];
               req_d.data  = wr_data;
               cnt_d       = busy_load;
               state_d     = MEM_BUSY;
               ready_d     = 1'b0;
            end
         end
         MEM_BUSY: begin
            ready_d = 1'b0;
            // Commit on the terminal count so a following read sees this write.
            if (cnt_q == '0) begin
               commit_wr = req_q.write;
               commit_rd = !req_q.write;
               state_d   = MEM_IDLE;
               ready_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = MEM_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= MEM_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         ready_q <= 1'b1;
         rd_data <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         ready_q <= ready_d;
         if (commit_rd) rd_data <= mem[req_q.idx];
      end
   end

   // Storage is deliberately not reset; a reset mid-request never reaches commit.
   always_ff @(posedge clk_i) begin
      if (commit_wr) mem[req_q.idx] <= req_q.data;
   end

   assign ready = ready_q;

endmodule
